// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: the NOP encoding, the default reset PC
// and the fetch-stage state encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Next sequential PC; wraps modulo 2^32 like the hardware adder.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for the fetch tag queue and the instruction buffer.
// Flush empties it and overrides push/pop; push while full is allowed only with a pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, in-order IMEM requests, response buffering, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds the o_BubbleCnt bubble counter output.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH   = 32,
    parameter int                       INSTR_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC        = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    parameter int                       MAX_OUTSTANDING = 2,
    parameter int                       BUF_DEPTH       = 2
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_StallF,
    input  logic                     i_StallD,
    input  logic                     i_FlushD,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    output logic                     o_IMemReqValid,
    input  logic                     i_IMemReqReady,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemRspValid,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRspData,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD,
`ifdef FETCH_PERF_CNT_EN
    output logic                     o_FetchBusy,
    output logic [31:0]              o_BubbleCnt
`else
    output logic                     o_FetchBusy
`endif
);

    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W   = $clog2(MAX_OUTSTANDING + BUF_DEPTH + 1);
    localparam int ENTRY_W = INSTR_WIDTH + ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] pc_r;
    fetch_state_e             state_r;
    fetch_state_e             state_next_s;
    logic [OUT_W-1:0]         discard_r;
    logic [OUT_W-1:0]         discard_next_s;

    logic [INSTR_WIDTH-1:0]   ifid_instr_r;
    logic [ADDRESS_WIDTH-1:0] ifid_pcplus4_r;
    logic                     ifid_valid_r;
    logic [INSTR_WIDTH-1:0]   ifid_instr_next_s;
    logic [ADDRESS_WIDTH-1:0] ifid_pcplus4_next_s;
    logic                     ifid_valid_next_s;
    logic                     bubble_s;

    // Tag FIFO occupancy is the outstanding-request count.
    logic [ADDRESS_WIDTH-1:0] tag_head_s;
    logic                     tag_full_s;
    logic                     tag_empty_s;
    logic [OUT_W-1:0]         tag_count_s;

    logic [ENTRY_W-1:0]       buf_head_s;
    logic                     buf_full_s;
    logic                     buf_empty_s;
    logic [BCNT_W-1:0]        buf_count_s;
    logic                     buf_push_s;
    logic                     buf_pop_s;

    logic [SUM_W-1:0]         occupancy_s;
    logic                     req_valid_s;
    logic                     accept_s;
    logic                     rsp_s;
    logic                     drop_s;
    logic                     keep_s;
    logic                     bypass_s;

    // In-flight limits count discarded requests too, so the buffer can never overflow.
    assign occupancy_s = SUM_W'(tag_count_s) + SUM_W'(buf_count_s);
    assign req_valid_s = ~i_RST & ~i_StallF & ~i_PCSrcD & ~tag_full_s & ~buf_full_s
                       & (occupancy_s < SUM_W'(BUF_DEPTH));
    assign accept_s    = req_valid_s & i_IMemReqReady;

    // Responses with nothing outstanding (e.g. after reset) are ignored.
    assign rsp_s       = i_IMemRspValid & ~tag_empty_s & ~i_RST;
    assign drop_s      = rsp_s & (i_PCSrcD | (discard_r != {OUT_W{1'b0}}));
    assign keep_s      = rsp_s & ~drop_s;
    assign bypass_s    = keep_s & buf_empty_s & ~i_StallD & ~i_FlushD;
    assign buf_push_s  = keep_s & ~bypass_s;

    assign o_IMemReqValid = req_valid_s;
    assign o_IMemAddr     = pc_r;
    assign o_InstrD       = ifid_instr_r;
    assign o_PCPlus4D     = ifid_pcplus4_r;
    assign o_ValidD       = ifid_valid_r;
    assign o_FetchBusy    = ~tag_empty_s;

    fetch_fifo #(
        .WIDTH (ADDRESS_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (i_CLK),
        .rst       (i_RST),
        .flush     (1'b0),
        .push      (accept_s),
        .push_data (pc_r + ADDRESS_WIDTH'(4)),
        .pop       (rsp_s),
        .pop_data  (tag_head_s),
        .full      (tag_full_s),
        .empty     (tag_empty_s),
        .count     (tag_count_s)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_instr_buf (
        .clk       (i_CLK),
        .rst       (i_RST),
        .flush     (i_PCSrcD),
        .push      (buf_push_s),
        .push_data ({i_IMemRspData, tag_head_s}),
        .pop       (buf_pop_s),
        .pop_data  (buf_head_s),
        .full      (buf_full_s),
        .empty     (buf_empty_s),
        .count     (buf_count_s)
    );

    // Program counter: reset, redirect, then sequential advance on acceptance.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pc_r <= RESET_PC;
        end else if (i_PCSrcD) begin
            pc_r <= i_PCNextD;
        end else if (accept_s) begin
            pc_r <= pc_r + ADDRESS_WIDTH'(4);
        end
    end

    // Drain state and stale-response counter registers.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r   <= RUN;
            discard_r <= {OUT_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            discard_r <= discard_next_s;
        end
    end

    // A redirect marks every request still in flight after this cycle's response as stale.
    always_comb begin
        state_next_s   = state_r;
        discard_next_s = discard_r;
        if (i_PCSrcD) begin
            discard_next_s = tag_count_s - OUT_W'(rsp_s);
        end else if (drop_s) begin
            discard_next_s = discard_r - OUT_W'(1);
        end else begin
            discard_next_s = discard_r;
        end
        case (state_r)
            RUN: begin
                if (i_PCSrcD && (discard_next_s != {OUT_W{1'b0}})) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (discard_next_s == {OUT_W{1'b0}}) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = RUN;
        endcase
    end

    // IF/ID source select: stall, flush, buffer head, bypassed response, else bubble.
    always_comb begin
        ifid_instr_next_s   = ifid_instr_r;
        ifid_pcplus4_next_s = ifid_pcplus4_r;
        ifid_valid_next_s   = ifid_valid_r;
        buf_pop_s           = 1'b0;
        bubble_s            = 1'b0;
        if (i_StallD) begin
            ifid_valid_next_s = ifid_valid_r;
        end else if (i_FlushD) begin
            ifid_instr_next_s   = INSTR_WIDTH'(NOP_INSTR);
            ifid_pcplus4_next_s = {ADDRESS_WIDTH{1'b0}};
            ifid_valid_next_s   = 1'b0;
        end else if (!buf_empty_s) begin
            ifid_instr_next_s   = buf_head_s[ENTRY_W-1:ADDRESS_WIDTH];
            ifid_pcplus4_next_s = buf_head_s[ADDRESS_WIDTH-1:0];
            ifid_valid_next_s   = 1'b1;
            buf_pop_s           = 1'b1;
        end else if (bypass_s) begin
            ifid_instr_next_s   = i_IMemRspData;
            ifid_pcplus4_next_s = tag_head_s;
            ifid_valid_next_s   = 1'b1;
        end else begin
            ifid_instr_next_s   = INSTR_WIDTH'(NOP_INSTR);
            ifid_pcplus4_next_s = {ADDRESS_WIDTH{1'b0}};
            ifid_valid_next_s   = 1'b0;
            bubble_s            = 1'b1;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            ifid_instr_r   <= INSTR_WIDTH'(NOP_INSTR);
            ifid_pcplus4_r <= {ADDRESS_WIDTH{1'b0}};
            ifid_valid_r   <= 1'b0;
        end else begin
            ifid_instr_r   <= ifid_instr_next_s;
            ifid_pcplus4_r <= ifid_pcplus4_next_s;
            ifid_valid_r   <= ifid_valid_next_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;

    assign o_BubbleCnt = bubble_cnt_r;

    // Saturating count of starvation bubbles (stall/flush bubbles excluded).
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            bubble_cnt_r <= 32'd0;
        end else if (bubble_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle instruction memory model.
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        i_RST = 1'b0;
    logic        i_StallF = 1'b0;
    logic        i_StallD = 1'b0;
    logic        i_FlushD = 1'b0;
    logic        i_PCSrcD = 1'b0;
    logic [31:0] i_PCNextD = 32'd0;
    logic        i_IMemReqReady = 1'b0;
    logic        i_IMemRspValid = 1'b0;
    logic [31:0] i_IMemRspData = 32'd0;
    logic        o_IMemReqValid;
    logic [31:0] o_IMemAddr;
    logic [31:0] o_InstrD;
    logic [31:0] o_PCPlus4D;
    logic        o_ValidD;
    logic        o_FetchBusy;

    int          checks = 0;
    int          errors = 0;
    logic        auto_rsp = 1'b0;

    fetch_stage dut (
        .i_CLK          (clk),
        .i_RST          (i_RST),
        .i_StallF       (i_StallF),
        .i_StallD       (i_StallD),
        .i_FlushD       (i_FlushD),
        .i_PCSrcD       (i_PCSrcD),
        .i_PCNextD      (i_PCNextD),
        .o_IMemReqValid (o_IMemReqValid),
        .i_IMemReqReady (i_IMemReqReady),
        .o_IMemAddr     (o_IMemAddr),
        .i_IMemRspValid (i_IMemRspValid),
        .i_IMemRspData  (i_IMemRspData),
        .o_InstrD       (o_InstrD),
        .o_PCPlus4D     (o_PCPlus4D),
        .o_ValidD       (o_ValidD),
        .o_FetchBusy    (o_FetchBusy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // One clock: record a handshake, cross the edge, then present the memory response.
    task automatic cyc();
        logic        fire;
        logic [31:0] a;
        fire = o_IMemReqValid & i_IMemReqReady;
        a    = o_IMemAddr;
        @(posedge clk);
        #1;
        if (auto_rsp && fire) begin
            i_IMemRspValid = 1'b1;
            i_IMemRspData  = mk(a);
        end else begin
            i_IMemRspValid = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_RST = 1'b1; i_StallF = 1'b0; i_StallD = 1'b0; i_FlushD = 1'b0;
        i_PCSrcD = 1'b0; i_IMemReqReady = 1'b0; auto_rsp = 1'b0; i_IMemRspValid = 1'b0;
        cyc();
        cyc();
        i_RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        i_RST = 1'b1;
        cyc();
        cyc();
        settle();
        check_eq("rst_reqvalid", 32'(o_IMemReqValid), 32'd0);
        check_eq("rst_addr",     o_IMemAddr,          32'h0);
        check_eq("rst_busy",     32'(o_FetchBusy),    32'd0);
        check_eq("rst_validd",   32'(o_ValidD),       32'd0);
        check_eq("rst_instrd",   o_InstrD,            32'h0);
        check_eq("rst_pcplus4",  o_PCPlus4D,          32'h0);

        // Streaming with 1-cycle memory
        i_RST = 1'b0; i_IMemReqReady = 1'b1; auto_rsp = 1'b1;
        for (int n = 0; n < 8; n++) begin
            settle();
            check_eq("str_addr",  o_IMemAddr,           32'(4 * n));
            check_eq("str_valid", 32'(o_IMemReqValid),  32'd1);
            if (n >= 2) begin
                check_eq("str_validd", 32'(o_ValidD), 32'd1);
                check_eq("str_instr",  o_InstrD,      mk(32'(4 * (n - 2))));
                check_eq("str_pc4",    o_PCPlus4D,    32'(4 * (n - 1)));
            end else begin
                check_eq("str_validd0", 32'(o_ValidD), 32'd0);
            end
            cyc();
        end

        // Redirect with two stale responses in flight
        do_reset();
        i_IMemReqReady = 1'b1;
        i_PCSrcD = 1'b1; i_PCNextD = 32'h10;
        settle();
        check_eq("redir_noreq", 32'(o_IMemReqValid), 32'd0);
        cyc();
        i_PCSrcD = 1'b0;
        settle();
        check_eq("redir_addr10", o_IMemAddr, 32'h10);
        cyc();
        settle();
        check_eq("redir_addr14", o_IMemAddr, 32'h14);
        check_eq("redir_v14",    32'(o_IMemReqValid), 32'd1);
        cyc();
        settle();
        check_eq("max_out_noreq", 32'(o_IMemReqValid), 32'd0);
        check_eq("max_out_busy",  32'(o_FetchBusy),    32'd1);
        i_PCSrcD = 1'b1; i_PCNextD = 32'h100;
        settle();
        cyc();
        i_PCSrcD = 1'b0; i_IMemRspValid = 1'b1; i_IMemRspData = mk(32'h10);
        settle();
        check_eq("drain_addr",  o_IMemAddr,          32'h100);
        check_eq("drain_noreq", 32'(o_IMemReqValid), 32'd0);
        check_eq("drain_state", 32'(dut.state_r),    32'(DRAIN));
        cyc();
        i_IMemRspValid = 1'b1; i_IMemRspData = mk(32'h14);
        settle();
        check_eq("drain_req", 32'(o_IMemReqValid), 32'd1);
        cyc();
        i_IMemRspValid = 1'b1; i_IMemRspData = mk(32'h100); i_IMemReqReady = 1'b0;
        settle();
        check_eq("stale_dropped", 32'(o_ValidD),    32'd0);
        check_eq("run_state",     32'(dut.state_r), 32'(RUN));
        cyc();
        settle();
        check_eq("redir_instr",  o_InstrD,         mk(32'h100));
        check_eq("redir_pc4",    o_PCPlus4D,       32'h104);
        check_eq("redir_validd", 32'(o_ValidD),    32'd1);
        check_eq("redir_idle",   32'(o_FetchBusy), 32'd0);

        // Decode stall fills the buffer, then drains in order
        do_reset();
        i_IMemReqReady = 1'b1; auto_rsp = 1'b1;
        settle(); cyc();
        settle(); cyc();
        i_StallD = 1'b1;
        settle();
        check_eq("stall_instr0", o_InstrD, mk(32'h0));
        cyc();
        settle();
        check_eq("stall_noreq3", 32'(o_IMemReqValid), 32'd0);
        check_eq("stall_hold3",  o_InstrD,            mk(32'h0));
        cyc();
        settle();
        check_eq("stall_noreq4", 32'(o_IMemReqValid), 32'd0);
        check_eq("stall_hold4",  o_PCPlus4D,          32'h4);
        check_eq("stall_buf",    32'(dut.buf_count_s), 32'd2);
        cyc();
        i_StallD = 1'b0;
        settle();
        cyc();
        settle();
        check_eq("rel_instr4", o_InstrD,   mk(32'h4));
        check_eq("rel_pc8",    o_PCPlus4D, 32'h8);
        cyc();
        settle();
        check_eq("rel_instr8", o_InstrD,   mk(32'h8));
        check_eq("rel_pc12",   o_PCPlus4D, 32'hC);
        cyc();
        settle();
        check_eq("rel_instr12", o_InstrD,   mk(32'hC));
        check_eq("rel_pc16",    o_PCPlus4D, 32'h10);

        // Decode flush loads a bubble
        do_reset();
        i_IMemReqReady = 1'b1; auto_rsp = 1'b1;
        for (int n = 0; n < 4; n++) begin
            settle(); cyc();
        end
        i_FlushD = 1'b1;
        settle();
        check_eq("preflush_validd", 32'(o_ValidD), 32'd1);
        cyc();
        i_FlushD = 1'b0;
        settle();
        check_eq("flush_validd", 32'(o_ValidD), 32'd0);
        check_eq("flush_instr",  o_InstrD,      32'h0);
        check_eq("flush_pc4",    o_PCPlus4D,    32'h0);

        // Fetch stall blocks issue
        do_reset();
        i_IMemReqReady = 1'b1; i_StallF = 1'b1;
        for (int n = 0; n < 3; n++) begin
            settle();
            check_eq("stallf_noreq", 32'(o_IMemReqValid), 32'd0);
            check_eq("stallf_addr",  o_IMemAddr,          32'h0);
            cyc();
        end
        i_StallF = 1'b0;
        settle();
        check_eq("stallf_rel", 32'(o_IMemReqValid), 32'd1);
        cyc();
        settle();
        check_eq("stallf_adv", o_IMemAddr, 32'h4);

        // Back-pressure holds valid and address
        do_reset();
        auto_rsp = 1'b1;
        for (int n = 0; n < 4; n++) begin
            settle();
            check_eq("bp_valid", 32'(o_IMemReqValid), 32'd1);
            check_eq("bp_addr",  o_IMemAddr,          32'h0);
            cyc();
        end
        i_IMemReqReady = 1'b1;
        settle();
        check_eq("bp_acc_addr", o_IMemAddr, 32'h0);
        cyc();
        settle();
        check_eq("bp_adv_addr", o_IMemAddr,       32'h4);
        check_eq("bp_busy",     32'(o_FetchBusy), 32'd1);

        // Reset mid-stream with a late response
        do_reset();
        i_IMemReqReady = 1'b1;
        settle(); cyc();
        i_IMemReqReady = 1'b0; i_RST = 1'b1;
        settle();
        check_eq("mid_busy_pre", 32'(o_FetchBusy),    32'd1);
        check_eq("mid_noreq",    32'(o_IMemReqValid), 32'd0);
        cyc();
        i_RST = 1'b0; i_StallF = 1'b1; i_IMemRspValid = 1'b1; i_IMemRspData = mk(32'h0);
        settle();
        check_eq("mid_addr",   o_IMemAddr,       32'h0);
        check_eq("mid_busy",   32'(o_FetchBusy), 32'd0);
        check_eq("mid_validd", 32'(o_ValidD),    32'd0);
        cyc();
        i_StallF = 1'b0; i_IMemReqReady = 1'b1;
        settle();
        check_eq("late_ignored", 32'(o_ValidD),        32'd0);
        check_eq("late_instr",   o_InstrD,             32'h0);
        check_eq("late_busy",    32'(o_FetchBusy),     32'd0);
        check_eq("restart_v",    32'(o_IMemReqValid),  32'd1);
        check_eq("restart_addr", o_IMemAddr,           32'h0);
        cyc();
        i_IMemReqReady = 1'b0; i_IMemRspValid = 1'b1; i_IMemRspData = mk(32'h0);
        settle();
        cyc();
        settle();
        check_eq("restart_instr", o_InstrD,      mk(32'h0));
        check_eq("restart_pc4",   o_PCPlus4D,    32'h4);
        check_eq("restart_vd",    32'(o_ValidD), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
